// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder: operands and start from the master,
// handshake status and result from the slave.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin, sub,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Optional subtract path is built only when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus,
  output logic [1:0]    dbg_state_o
);

  // Handshake: a request is accepted on any rising edge where start=1 and
  // ready=1; done pulses for one cycle when sum/cout become valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               accept;
  logic               fa_s;
  logic               fa_c;
  logic               last_bit;

  assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign accept   = (state_q != RUN) && bus.start;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifndef SERIAL_ADDER_SUB_EN
  logic sub_unused;
  assign sub_unused = bus.sub;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sh_d = bus.a;
      cnt_d  = '0;
`ifdef SERIAL_ADDER_SUB_EN
      // a - b computed as a + ~b + 1; cout=1 then means no borrow.
      b_sh_d  = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? 1'b1 : bus.cin;
`else
      b_sh_d  = bus.b;
      carry_d = bus.cin;
`endif
    end

    if (state_q == RUN) begin
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + 1'b1;
      if (last_bit) cout_d = fa_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.ready   = (state_q != RUN);
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): hand-computed results queued in
// exp_q at each launch and checked when done pulses.
module tb_serial_adder;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         total;
  int         passed;
  logic [W:0] exp_q[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called away from the rising edge; returns #1 after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input bit push, input logic [W:0] exp);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Returns on the falling edge inside the done cycle.
  task automatic wait_done(input string tag, input bit chk_lat);
    int         n;
    int         busy_n;
    bit         seen;
    logic [W:0] e;
    n = 0; busy_n = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1;
      else if (bus.busy) busy_n++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (chk_lat) begin
      check({tag, "_latency"}, 32'(n - 1), 32'(W));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
    end
    check({tag, "_ready_in_done"}, 32'(bus.ready), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(bus.sum), 32'(e[W-1:0]));
      check({tag, "_cout"}, 32'(bus.cout), 32'(e[W]));
    end else begin
      check({tag, "_exp_q_empty"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int  done_n;
    total = 0; passed = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.sum),   32'd0);
    check("rst_cout",  32'(bus.cout),  32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 0x3A + 0x25 = 0x5F
    start_op(8'h3A, 8'h25, 1'b0, 1'b0, 1, 9'h05F);
    wait_done("add_3a_25", 1);
    @(negedge clk);
    check("single_done_pulse", 32'(bus.done), 32'd0);
    check("back_to_idle", 32'(dbg_state), 32'd0);
    check("sum_held", 32'(bus.sum), 32'h5F);

    // Carry-out and carry-in boundaries
    start_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 9'h100);
    wait_done("add_ff_01", 1);
    @(negedge clk);
    start_op(8'h00, 8'h00, 1'b1, 1'b0, 1, 9'h001);
    wait_done("add_cin", 1);
    @(negedge clk);

    // Back-to-back: second request accepted in the done cycle
    start_op(8'h11, 8'h22, 1'b0, 1'b0, 1, 9'h033);
    wait_done("b2b_first", 1);
    start_op(8'h80, 8'h80, 1'b0, 1'b0, 1, 9'h100);
    wait_done("b2b_second", 1);
    @(negedge clk);
    check("b2b_single_done", 32'(bus.done), 32'd0);

    // start during RUN must be ignored
    start_op(8'h10, 8'h20, 1'b0, 1'b0, 1, 9'h030);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    @(negedge clk);
    check("interfere_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("interfere", 0);
    @(negedge clk);
    check("interfere_single_done", 32'(bus.done), 32'd0);

    // Asynchronous reset mid-run aborts without done
    start_op(8'h55, 8'h0F, 1'b0, 1'b0, 0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sum",   32'(bus.sum),   32'd0);
    check("midrst_busy",  32'(bus.busy),  32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_done",  32'(bus.done),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("midrst_no_done", 32'(done_n), 32'd0);
    start_op(8'h01, 8'h02, 1'b0, 1'b0, 1, 9'h003);
    wait_done("after_rst", 1);
    @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h05, 8'h07, 1'b0, 1'b1, 1, 9'h0FE);
    wait_done("sub_5_7", 1);
    @(negedge clk);
    start_op(8'h07, 8'h05, 1'b0, 1'b1, 1, 9'h102);
    wait_done("sub_7_5", 1);
    @(negedge clk);
`else
    // sub is ignored in the add-only build: 0x05 + 0x07 = 0x0C
    start_op(8'h05, 8'h07, 1'b0, 1'b1, 1, 9'h00C);
    wait_done("sub_ignored", 1);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that drives one fulladder-equivalent cell, one bit per clock, LSB first.
- Operand shift registers feed the cell's a/b inputs, and a carry flip-flop closes the cin→cout loop.
- Sum bits shift into a result register.
- Sits between operand registers and the datapath result bus; trades area for WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- sub  input  1  subtract select, captured on accepted start (only used with SERIAL_ADDER_SUB_EN)
- ready  output  1  high in IDLE and DONE; start accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  final carry, held with sum

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, shift regs=0, carry=0, count=0.
- States:
  - IDLE→RUN on start=1.
  - RUN→RUN while count<WIDTH-1.
  - RUN→DONE at the edge processing bit WIDTH-1.
  - DONE→RUN on start=1, else DONE→IDLE.
- Accept edge (start=1 while ready=1):
  - a_sh←a, b_sh←b, carry←cin, count←0.
  - sum and cout are not cleared here; they change only during RUN.
- Each RUN edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - c = (a_sh[0]&b_sh[0])|(a_sh[0]&carry)|(b_sh[0]&carry).
  - sum←{s, sum[WIDTH-1:1]}; a_sh, b_sh shift right by 1; carry←c; count←count+1.
- At the final RUN edge, cout←c. cout is otherwise stable.
- Latency: done is high during the cycle that starts WIDTH edges after the accept edge. Example: WIDTH=8 gives 8 cycles.
- done is asserted only in DONE, for exactly one cycle.
- start while busy=1 is ignored. Operands are already latched, so a/b/cin may change freely during RUN.
- start in the DONE cycle is accepted (back-to-back). done still pulses, and the next result follows WIDTH cycles later.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the true sum.
- Reset mid-RUN aborts the operation; no done is issued. The first start after reset release behaves normally.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: on accept, if sub=1 then b_sh←~b and carry←1, and cin is ignored.
  - Result: sum = a−b mod 2^WIDTH; cout=1 means no borrow (a≥b unsigned).
  - If sub=0, behaviour is identical to the add path.
- Undefined: the sub port exists but is ignored; no inverter or mux is built; add-only.

Test Plan:
- WIDTH=8, a=0x3A, b=0x25, cin=0, start 1 cycle → done exactly 8 cycles after accept; sum=0x5F, cout=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Back-to-back: start held high through the done cycle with new a=0x80, b=0x80 → second done 8 cycles later, sum=0x00, cout=1.
- Mid-run interference: a=0x10, b=0x20 accepted; at cycle 3 drive start=1 with a=0xFF → ignored; result sum=0x30, single done.
- Reset mid-run: assert rst at cycle 4 for 1 cycle → outputs zero immediately (async), no done. Next op 0x01+0x02 → sum=0x03.
- With SERIAL_ADDER_SUB_EN, sub=1:
  - a=0x05, b=0x07 → sum=0xFE, cout=0.
  - a=0x07, b=0x05 → sum=0x02, cout=1.
